mem_stage_pipe: RTL and testbench
=================================

Name: mem_stage_pipe

Overview:
Parametrised memory pipeline stage for the WISC-style processor. It replaces the fixed single-cycle memory stage with one that drives a variable-latency memory port through a request/done handshake, stalls upstream while an access is outstanding, and selects write-back data from a widened source set. The EX/MEM side feeds it, and its registered MEM/WB outputs feed write-back. It detects illegal write-back source selects, unaligned accesses and memory timeouts, and latches halt.

Parameters:
DATA_W, 16, datapath/register width (>=16)
ADDR_W, 16, memory address width (<=DATA_W; address = alu_out[ADDR_W-1:0])
REG_IDX_W, 3, register index width
TIMEOUT, 64, max cycles in WAIT before timeout error (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
valid_in  in  1  EX/MEM holds a valid instruction
alu_out  in  DATA_W  ALU result / memory address
set_val  in  DATA_W  set-instruction result
store_data  in  DATA_W  memory write data
reg1_data  in  DATA_W  source register 1 data
next_pc  in  DATA_W  PC+2 (link value)
instr  in  16  instruction word
mem_en  in  1  memory access requested
mem_wr  in  1  1 = store, 0 = load
reg_wrt  in  1  write-back enable
reg_wrt_src  in  3  write-back source select
write_reg  in  REG_IDX_W  destination register
halt  in  1  halt instruction
mem_req  out  1  memory request, held until mem_done
mem_wr_o  out  1  request is a write
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  request write data
mem_rdata  in  DATA_W  read data, valid with mem_done
mem_done  in  1  one-cycle completion pulse
stall  out  1  upstream must hold its EX/MEM inputs
fwd_data  out  DATA_W  combinational forward value (0 for src 0)
wb_valid  out  1  MEM/WB holds a retired instruction
mem_out  out  DATA_W  registered load data
reg_write_data  out  DATA_W  registered fwd_data
reg_wrt_out  out  1  registered reg_wrt & retire
write_reg_out  out  REG_IDX_W  registered write_reg
reg_wrt_src_out  out  3  registered reg_wrt_src
halt_out  out  1  sticky halt
err  out  1  sticky error
dump  out  1  one-cycle memory dump pulse

Behaviour:
- Reset: state IDLE; timeout counter 0; all outputs 0.
- Asserting reset mid-WAIT drops mem_req immediately.
- "accept" = valid_in & ~halt_out & ~err.
- fwd_data by src:
  - 0: 0
  - 1: alu_out
  - 2: next_pc
  - 3: set_val
  - 4: sign-extend instr[7:0] to DATA_W
  - 5: {reg1_data[DATA_W-9:0], instr[7:0]}
  - 6: bit-reverse of reg1_data
  - 7: 0 and illegal.
- IDLE, accept & mem_en & alu_out[0]==0:
  - mem_req=1 combinationally, with mem_wr_o/addr/wdata taken from the inputs.
  - mem_done the same cycle: retire in that cycle, stall=0.
  - Otherwise: stall=1, go to WAIT, capture the request into internal registers.
- WAIT:
  - mem_req=1 from the captured registers; stall=1 until mem_done.
  - Retire on the mem_done cycle, stall=0, return to IDLE.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT-1 without mem_done: err=1, mem_req drops next cycle, return to IDLE, no retire.
- Retire (on a clk edge):
  - wb_valid=1.
  - mem_out = mem_rdata for loads, 0 for stores and non-memory ops.
  - reg_write_data = fwd_data; write_reg_out, reg_wrt_src_out and reg_wrt_out=reg_wrt load from the inputs.
- Non-memory accepted instructions retire one cycle after presentation, with no stall.
- Cycles with no retire: wb_valid=0 and reg_wrt_out=0; other MEM/WB outputs hold.
- Errors (sticky until reset):
  - accept & reg_wrt_src==7.
  - accept & mem_en & alu_out[0]==1: unaligned; no request, no retire.
  - Timeout.
- halt:
  - accept & halt retires normally; halt_out=1 (sticky).
  - After halt_out or err, valid_in is ignored: no requests, stall=0, wb_valid=0.
- dump pulses 1 cycle on the first rising of halt_out or err. If both rise together, a single pulse.
- mem_done in IDLE with no request: ignored.
- A new request is never issued in the same cycle as a completion in WAIT.

Test Plan:
- Src sweep: valid_in=1, mem_en=0, alu_out=16'h1234, reg1_data=16'h00F1, instr[7:0]=8'h85, src 1..6 -> reg_write_data = 1234, next_pc, set_val, FF85, F185, 8F00 respectively, each a cycle later with wb_valid=1 and stall=0.
- Zero-wait load: mem_en=1, mem_wr=0, addr 16'h0040, mem_done same cycle with mem_rdata=16'hBEEF -> stall=0, next cycle mem_out=BEEF, wb_valid=1.
- 3-wait store: data 16'hA5A5 to addr 16'h0100 -> mem_req held 4 cycles with constant addr/wdata, stall=1 for 3 cycles, wb_valid=0 during them, then 1; mem_out=0.
- Unaligned load at 16'h0041 -> mem_req never asserts, err=1 next cycle, dump pulses once, later valid_in ignored.
- Timeout: TIMEOUT=4, no mem_done -> err=1 after 4 WAIT cycles, mem_req low the following cycle, wb_valid stays 0.
- Halt then reset: halt retires -> halt_out=1 and single dump pulse, subsequent loads issue no mem_req; assert rst mid-WAIT of a fresh request -> mem_req and all outputs 0 immediately.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// Memory pipeline stage: drives a variable-latency memory port through a
// request/done handshake, stalls upstream while an access is outstanding,
// selects write-back data and registers the MEM/WB outputs. Flags illegal
// write-back selects, unaligned accesses and memory timeouts; latches halt.
module mem_stage_pipe #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int REG_IDX_W = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic [DATA_W-1:0]    set_val,
    input  logic [DATA_W-1:0]    store_data,
    input  logic [DATA_W-1:0]    reg1_data,
    input  logic [DATA_W-1:0]    next_pc,
    input  logic [15:0]          instr,
    input  logic                 mem_en,
    input  logic                 mem_wr,
    input  logic                 reg_wrt,
    input  logic [2:0]           reg_wrt_src,
    input  logic [REG_IDX_W-1:0] write_reg,
    input  logic                 halt,
    output logic                 mem_req,
    output logic                 mem_wr_o,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_done,
    output logic                 stall,
    output logic [DATA_W-1:0]    fwd_data,
    output logic                 wb_valid,
    output logic [DATA_W-1:0]    mem_out,
    output logic [DATA_W-1:0]    reg_write_data,
    output logic                 reg_wrt_out,
    output logic [REG_IDX_W-1:0] write_reg_out,
    output logic [2:0]           reg_wrt_src_out,
    output logic                 halt_out,
    output logic                 err,
    output logic                 dump
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                cap_wr;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;

    logic                accept;
    logic                unaligned;
    logic                retire;
    logic                is_load;
    logic                timeout;
    logic                set_err;
    logic                set_halt;
    logic [DATA_W-1:0]   rev;

    // Upper instruction byte is not needed by this stage.
    logic unused_instr_hi;
    assign unused_instr_hi = &{1'b0, instr[15:8]};

    // Bit-reverse of reg1_data for write-back source 6.
    always_comb begin
        rev = '0;
        for (int i = 0; i < DATA_W; i++) rev[i] = reg1_data[DATA_W-1-i];
    end

    // Write-back data select; source 7 is illegal and forwards zero.
    always_comb begin
        fwd_data = '0;
        case (reg_wrt_src)
            3'd1:    fwd_data = alu_out;
            3'd2:    fwd_data = next_pc;
            3'd3:    fwd_data = set_val;
            3'd4:    fwd_data = {{(DATA_W-8){instr[7]}}, instr[7:0]};
            3'd5:    fwd_data = {reg1_data[DATA_W-9:0], instr[7:0]};
            3'd6:    fwd_data = rev;
            default: fwd_data = '0;
        endcase
    end

    // Handshake decode: request, stall, retire and error conditions.
    // Reset gates accept and the WAIT request so the port drops at once.
    always_comb begin
        accept    = valid_in & ~halt_out & ~err & ~rst;
        unaligned = accept & mem_en & alu_out[0];
        mem_req   = 1'b0;
        mem_wr_o  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall     = 1'b0;
        retire    = 1'b0;
        is_load   = 1'b0;
        timeout   = 1'b0;
        if (state == IDLE) begin
            if (accept & mem_en & ~alu_out[0]) begin
                mem_req   = 1'b1;
                mem_wr_o  = mem_wr;
                mem_addr  = alu_out[ADDR_W-1:0];
                mem_wdata = store_data;
                stall     = ~mem_done;
                retire    = mem_done;
                is_load   = ~mem_wr;
            end else begin
                retire = accept & ~mem_en;
            end
        end else if (!rst) begin
            mem_req   = 1'b1;
            mem_wr_o  = cap_wr;
            mem_addr  = cap_addr;
            mem_wdata = cap_wdata;
            stall     = ~mem_done;
            retire    = mem_done;
            is_load   = ~cap_wr;
            timeout   = ~mem_done & (cnt == CNT_W'(TIMEOUT - 1));
        end
        set_err  = (accept & (reg_wrt_src == 3'd7)) | unaligned | timeout;
        set_halt = retire & halt;
    end

    // Access FSM: capture the request on a stalled issue, count WAIT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (mem_req & ~mem_done) begin
                state     <= WAIT;
                cap_wr    <= mem_wr_o;
                cap_addr  <= mem_addr;
                cap_wdata <= mem_wdata;
            end
        end else begin
            if (mem_done | timeout) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // MEM/WB register: load on retire, otherwise only the valids clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid        <= 1'b0;
            mem_out         <= '0;
            reg_write_data  <= '0;
            reg_wrt_out     <= 1'b0;
            write_reg_out   <= '0;
            reg_wrt_src_out <= '0;
        end else if (retire) begin
            wb_valid        <= 1'b1;
            mem_out         <= is_load ? mem_rdata : '0;
            reg_write_data  <= fwd_data;
            reg_wrt_out     <= reg_wrt;
            write_reg_out   <= write_reg;
            reg_wrt_src_out <= reg_wrt_src;
        end else begin
            wb_valid    <= 1'b0;
            reg_wrt_out <= 1'b0;
        end
    end

    // Sticky halt/error flags and a single dump pulse on the first of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_out <= 1'b0;
            err      <= 1'b0;
            dump     <= 1'b0;
        end else begin
            if (set_halt) halt_out <= 1'b1;
            if (set_err)  err      <= 1'b1;
            dump <= (set_halt | set_err) & ~halt_out & ~err;
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe with a retire scoreboard.
module tb_mem_stage_pipe;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] alu_out, set_val, store_data, reg1_data, next_pc;
    logic [15:0]   instr;
    logic          mem_en, mem_wr, reg_wrt, halt;
    logic [2:0]    reg_wrt_src;
    logic [2:0]    write_reg;
    logic          mem_req, mem_wr_o;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic          mem_done, stall;
    logic [DW-1:0] fwd_data;
    logic          wb_valid;
    logic [DW-1:0] mem_out, reg_write_data;
    logic          reg_wrt_out;
    logic [2:0]    write_reg_out, reg_wrt_src_out;
    logic          halt_out, err, dump;

    mem_stage_pipe #(.DATA_W(16), .ADDR_W(16), .REG_IDX_W(3), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .alu_out(alu_out),
        .set_val(set_val), .store_data(store_data), .reg1_data(reg1_data),
        .next_pc(next_pc), .instr(instr), .mem_en(mem_en), .mem_wr(mem_wr),
        .reg_wrt(reg_wrt), .reg_wrt_src(reg_wrt_src), .write_reg(write_reg),
        .halt(halt), .mem_req(mem_req), .mem_wr_o(mem_wr_o),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .stall(stall), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .mem_out(mem_out),
        .reg_write_data(reg_write_data), .reg_wrt_out(reg_wrt_out),
        .write_reg_out(write_reg_out), .reg_wrt_src_out(reg_wrt_src_out),
        .halt_out(halt_out), .err(err), .dump(dump)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rwd;
        logic [DW-1:0] mo;
        logic [2:0]    wr;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] rwd, input logic [DW-1:0] mo, input logic [2:0] wr);
        exp_t e;
        e.rwd = rwd; e.mo = mo; e.wr = wr;
        q.push_back(e);
    endtask

    // Compare a retiring MEM/WB entry against the oldest expectation.
    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, ".wb_valid"}, wb_valid, 1'b1);
        if (q.size() == 0) begin
            check({tag, ".sb_nonempty"}, 0, 1);
        end else begin
            e = q.pop_front();
            check({tag, ".rwd"}, reg_write_data, e.rwd);
            check({tag, ".mem_out"}, mem_out, e.mo);
            check({tag, ".wreg"}, write_reg_out, e.wr);
            check({tag, ".reg_wrt"}, reg_wrt_out, 1'b1);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 0; mem_en = 0; mem_wr = 0; mem_done = 0; halt = 0;
        reg_wrt = 1; reg_wrt_src = 3'd1; write_reg = 3'd1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        logic [DW-1:0] src_exp [1:6];
        alu_out = 16'h1234; set_val = 16'h0001; store_data = 16'h0000;
        reg1_data = 16'h00F1; next_pc = 16'h0202; instr = 16'h0085;
        mem_rdata = 16'h0000;
        idle_inputs();
        rst = 1;
        #2;
        tick();
        check("rst.wb_valid", wb_valid, 0);
        check("rst.mem_req", mem_req, 0);
        check("rst.stall", stall, 0);
        check("rst.err", err, 0);
        check("rst.halt_out", halt_out, 0);
        check("rst.dump", dump, 0);
        check("rst.rwd", reg_write_data, 0);
        check("rst.mem_out", mem_out, 0);
        rst = 0;

        // Source sweep, back to back, no memory access.
        src_exp[1] = 16'h1234; src_exp[2] = 16'h0202; src_exp[3] = 16'h0001;
        src_exp[4] = 16'hFF85; src_exp[5] = 16'hF185; src_exp[6] = 16'h8F00;
        for (int s = 1; s <= 6; s++) begin
            valid_in = 1; mem_en = 0; reg_wrt_src = 3'(s); write_reg = 3'(s);
            push(src_exp[s], 16'h0000, 3'(s));
            #1;
            check($sformatf("src%0d.stall", s), stall, 0);
            check($sformatf("src%0d.mem_req", s), mem_req, 0);
            tick();
            pop_check($sformatf("src%0d", s));
        end
        idle_inputs();
        tick();
        check("bubble.wb_valid", wb_valid, 0);
        check("bubble.reg_wrt", reg_wrt_out, 0);
        check("bubble.rwd_hold", reg_write_data, 16'h8F00);

        // Zero-wait load.
        valid_in = 1; mem_en = 1; mem_wr = 0; alu_out = 16'h0040;
        mem_done = 1; mem_rdata = 16'hBEEF; reg_wrt_src = 3'd1; write_reg = 3'd2;
        push(16'h0040, 16'hBEEF, 3'd2);
        #1;
        check("zw.mem_req", mem_req, 1);
        check("zw.addr", mem_addr, 16'h0040);
        check("zw.wr", mem_wr_o, 0);
        check("zw.stall", stall, 0);
        tick();
        idle_inputs();
        pop_check("zw");

        // Three-wait store.
        valid_in = 1; mem_en = 1; mem_wr = 1; alu_out = 16'h0100;
        store_data = 16'hA5A5; mem_rdata = 16'h1111; write_reg = 3'd3;
        push(16'h0100, 16'h0000, 3'd3);
        for (int i = 0; i < 4; i++) begin
            mem_done = (i == 3);
            #1;
            check($sformatf("st%0d.mem_req", i), mem_req, 1);
            check($sformatf("st%0d.addr", i), mem_addr, 16'h0100);
            check($sformatf("st%0d.wdata", i), mem_wdata, 16'hA5A5);
            check($sformatf("st%0d.wr", i), mem_wr_o, 1);
            check($sformatf("st%0d.stall", i), stall, (i < 3));
            tick();
            if (i < 3) check($sformatf("st%0d.wb_valid", i), wb_valid, 0);
        end
        idle_inputs();
        pop_check("st");
        #1;
        check("st.req_drop", mem_req, 0);

        // Unaligned load.
        valid_in = 1; mem_en = 1; mem_wr = 0; alu_out = 16'h0041;
        #1;
        check("ua.mem_req", mem_req, 0);
        tick();
        check("ua.err", err, 1);
        check("ua.dump", dump, 1);
        check("ua.wb_valid", wb_valid, 0);
        alu_out = 16'h0040;
        #1;
        check("ua.ign_req", mem_req, 0);
        check("ua.ign_stall", stall, 0);
        tick();
        check("ua.dump_once", dump, 0);
        check("ua.ign_wb", wb_valid, 0);
        check("ua.err_sticky", err, 1);

        // Illegal write-back source.
        do_reset();
        check("rst2.err", err, 0);
        valid_in = 1; mem_en = 0; reg_wrt_src = 3'd7;
        #1;
        check("src7.fwd", fwd_data, 0);
        tick();
        idle_inputs();
        check("src7.err", err, 1);
        check("src7.dump", dump, 1);
        q.delete();

        // Timeout with no completion.
        do_reset();
        valid_in = 1; mem_en = 1; mem_wr = 0; alu_out = 16'h0080;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("to%0d.mem_req", i), mem_req, 1);
            check($sformatf("to%0d.stall", i), stall, 1);
            tick();
            check($sformatf("to%0d.err", i), err, 0);
            check($sformatf("to%0d.wb_valid", i), wb_valid, 0);
        end
        tick();
        check("to.err", err, 1);
        check("to.dump", dump, 1);
        check("to.mem_req", mem_req, 0);
        check("to.wb_valid", wb_valid, 0);
        tick();
        check("to.wb_after", wb_valid, 0);
        idle_inputs();

        // Halt, then reset in the middle of a fresh request.
        do_reset();
        valid_in = 1; mem_en = 0; halt = 1; reg_wrt_src = 3'd2; write_reg = 3'd5;
        push(16'h0202, 16'h0000, 3'd5);
        tick();
        pop_check("halt");
        check("halt.halt_out", halt_out, 1);
        check("halt.dump", dump, 1);
        halt = 0; mem_en = 1; mem_wr = 0; alu_out = 16'h0040; reg_wrt_src = 3'd1;
        #1;
        check("halt.ign_req", mem_req, 0);
        check("halt.ign_stall", stall, 0);
        tick();
        check("halt.dump_once", dump, 0);
        check("halt.ign_wb", wb_valid, 0);

        do_reset();
        valid_in = 1; mem_en = 0; reg_wrt_src = 3'd3; write_reg = 3'd6;
        push(16'h0001, 16'h0000, 3'd6);
        tick();
        pop_check("pre");
        mem_en = 1; alu_out = 16'h0060;
        tick();
        check("mid.mem_req", mem_req, 1);
        rst = 1;
        #1;
        check("mid.req_drop", mem_req, 0);
        check("mid.stall", stall, 0);
        check("mid.wb_valid", wb_valid, 0);
        check("mid.rwd", reg_write_data, 0);
        check("mid.wreg", write_reg_out, 0);
        check("mid.halt_out", halt_out, 0);
        tick();
        rst = 0;
        idle_inputs();
        check("sb.empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case a wait above never completes.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
